// File: rtl/pc_gen_pkg.sv
// Shared types and width helpers for the fetch-PC generator.
package pc_gen_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_e;

    // Redirect bubble length is limited to 0..7.
    localparam int BUB_W = 3;

    function automatic int btb_idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int btb_tag_w(input int xlen, input int depth);
        return xlen - $clog2(depth) - 2;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Handshake/bus bundle between EX, stall control, IF and the fetch-PC generator.
interface pc_gen_if #(
    parameter int XLEN    = 32,
    parameter int STALL_W = 6
);
    logic               rdy_in;
    logic [STALL_W-1:0] stall_in;
    logic               ex_redirect_in;
    logic [XLEN-1:0]    ex_redirect_addr_in;
    logic               ex_upd_in;
    logic [XLEN-1:0]    ex_upd_pc_in;
    logic               ex_upd_taken_in;
    logic [XLEN-1:0]    ex_upd_target_in;
    logic               if_ready_in;
    logic [XLEN-1:0]    pc_out;
    logic               pc_valid_out;
    logic               pred_taken_out;
    logic [XLEN-1:0]    pred_target_out;

    modport master (
        output rdy_in, stall_in, ex_redirect_in, ex_redirect_addr_in,
               ex_upd_in, ex_upd_pc_in, ex_upd_taken_in, ex_upd_target_in,
               if_ready_in,
        input  pc_out, pc_valid_out, pred_taken_out, pred_target_out
    );

    modport slave (
        input  rdy_in, stall_in, ex_redirect_in, ex_redirect_addr_in,
               ex_upd_in, ex_upd_pc_in, ex_upd_taken_in, ex_upd_target_in,
               if_ready_in,
        output pc_out, pc_valid_out, pred_taken_out, pred_target_out
    );
endinterface

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer: combinational lookup, update on EX resolve.
module pc_gen_btb
    import pc_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [XLEN-1:0] lk_pc_i,
    output logic            hit_o,
    output logic [XLEN-1:0] lk_tgt_o,
    input  logic            upd_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_tgt_i
);
    localparam int IDX_W = btb_idx_w(DEPTH);
    localparam int TAG_W = btb_tag_w(XLEN, DEPTH);

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [XLEN-1:0]  tgt_q [DEPTH];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             upd_hit;

    assign lk_idx  = lk_pc_i[IDX_W+1:2];
    assign lk_tag  = lk_pc_i[XLEN-1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[XLEN-1:IDX_W+2];

    assign hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_tgt_o = tgt_q[lk_idx];
    assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Lookup reads the registered arrays, so a same-cycle update is seen next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (en_i && upd_i) begin
            if (upd_taken_i)
                valid_q[upd_idx] <= 1'b1;
            else if (upd_hit)
                valid_q[upd_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i && upd_i && upd_taken_i) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= upd_tgt_i;
        end
    end

    logic unused_sig;
    assign unused_sig = ^{lk_pc_i[1:0], upd_pc_i[1:0]};

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator with redirect bubble, rdy freeze and valid/ready toward IF.
// Optional BTB prediction is built when PC_BTB_EN is defined.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              FETCH_INC = 4,
    parameter int              STALL_W   = 6,
    parameter int              REDIR_BUB = 0,
    parameter int              BTB_DEPTH = 16
) (
    input  logic   clk_in,
    input  logic   rst_in,
    pc_gen_if.slave bus
);
    localparam logic [BUB_W-1:0] BUB_LD = BUB_W'(REDIR_BUB);

    pc_state_e        state_q;
    logic [XLEN-1:0]  pc_q;
    logic [BUB_W-1:0] cnt_q;
    logic             valid_q;

    logic [XLEN-1:0]  seq_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             advance;

    assign seq_pc = pc_q + XLEN'(FETCH_INC);

`ifdef PC_BTB_EN
    logic            btb_hit;
    logic [XLEN-1:0] btb_tgt;

    pc_gen_btb #(
        .XLEN  (XLEN),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .en_i        (bus.rdy_in),
        .lk_pc_i     (pc_q),
        .hit_o       (btb_hit),
        .lk_tgt_o    (btb_tgt),
        .upd_i       (bus.ex_upd_in),
        .upd_pc_i    (bus.ex_upd_pc_in),
        .upd_taken_i (bus.ex_upd_taken_in),
        .upd_tgt_i   (bus.ex_upd_target_in)
    );

    assign pred_taken  = btb_hit;
    assign pred_target = btb_hit ? btb_tgt : seq_pc;
`else
    assign pred_taken  = 1'b0;
    assign pred_target = seq_pc;

    logic unused_upd;
    assign unused_upd = ^{bus.ex_upd_in, bus.ex_upd_pc_in,
                          bus.ex_upd_taken_in, bus.ex_upd_target_in};
`endif

    assign advance = (state_q == ST_RUN) && valid_q && bus.if_ready_in && !bus.stall_in[0];

    // valid_q is the registered form of (RUN && bubble count == 0).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VEC;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.rdy_in) begin
            state_q <= ST_RUN;
            if (bus.ex_redirect_in) begin
                pc_q    <= {bus.ex_redirect_addr_in[XLEN-1:2], 2'b00};
                cnt_q   <= BUB_LD;
                valid_q <= (BUB_LD == '0);
            end else begin
                if (advance)
                    pc_q <= pred_target;
                if (cnt_q != '0) begin
                    cnt_q   <= cnt_q - 1'b1;
                    valid_q <= (cnt_q == BUB_W'(1));
                end else begin
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.pc_out          = pc_q;
    assign bus.pc_valid_out    = valid_q;
    assign bus.pred_taken_out  = pred_taken;
    assign bus.pred_target_out = pred_target;

    logic unused_stall;
    assign unused_stall = ^bus.stall_in;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios then random traffic vs. a reference model.
module tb_pc_gen;
    localparam int          BUB   = 2;
    localparam int          DEPTH = 16;
    localparam logic [31:0] RV    = 32'h0;
    localparam logic [31:0] INC   = 32'h4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32), .STALL_W(6)) bus ();

    pc_gen #(
        .XLEN(32), .RESET_VEC(RV), .FETCH_INC(4), .STALL_W(6),
        .REDIR_BUB(BUB), .BTB_DEPTH(DEPTH)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: current PC, started flag, remaining bubble cycles, BTB keyed by slot.
    logic [31:0] m_pc;
    bit          m_run;
    int          m_bub;
    logic [31:0] btb_br  [int];
    logic [31:0] btb_tgt [int];

    function automatic int slot(input logic [31:0] p);
        return int'((p >> 2) % DEPTH);
    endfunction

    function automatic bit m_hit(input logic [31:0] p);
`ifdef PC_BTB_EN
        return btb_br.exists(slot(p)) && (btb_br[slot(p)] == (p & ~32'h3));
`else
        return (p !== p);
`endif
    endfunction

    function automatic logic [31:0] m_pred(input logic [31:0] p);
        if (m_hit(p)) return btb_tgt[slot(p)];
        return p + INC;
    endfunction

    task automatic model_reset();
        m_pc  = RV;
        m_run = 0;
        m_bub = 0;
        btb_br.delete();
        btb_tgt.delete();
    endtask

    task automatic model_edge();
        logic [31:0] pred;
        bit          vld;
        logic [31:0] up;
        if (!bus.rdy_in) return;
        vld  = m_run && (m_bub == 0);
        pred = m_pred(m_pc);
`ifdef PC_BTB_EN
        if (bus.ex_upd_in) begin
            up = bus.ex_upd_pc_in & ~32'h3;
            if (bus.ex_upd_taken_in) begin
                btb_br[slot(up)]  = up;
                btb_tgt[slot(up)] = bus.ex_upd_target_in;
            end else if (btb_br.exists(slot(up)) && btb_br[slot(up)] == up) begin
                btb_br.delete(slot(up));
                btb_tgt.delete(slot(up));
            end
        end
`else
        up = '0;
`endif
        if (bus.ex_redirect_in) begin
            m_pc  = bus.ex_redirect_addr_in & ~32'h3;
            m_bub = BUB;
        end else begin
            if (m_bub > 0) m_bub--;
            if (vld && bus.if_ready_in && !bus.stall_in[0]) m_pc = pred;
        end
        m_run = 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    bus.pc_out, m_pc);
        chk({tag, ".valid"}, 32'(bus.pc_valid_out), 32'(m_run && m_bub == 0));
        chk({tag, ".ptkn"},  32'(bus.pred_taken_out), 32'(m_hit(m_pc)));
        chk({tag, ".ptgt"},  bus.pred_target_out, m_pred(m_pc));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Async reset pulse placed mid-cycle, checked before any clock edge.
    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".pc0"}, bus.pc_out, 32'h0);
        chk({tag, ".v0"},  32'(bus.pc_valid_out), 32'h0);
        #1 rst = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.rdy_in              = 1'b1;
        bus.stall_in            = '0;
        bus.ex_redirect_in      = 1'b0;
        bus.ex_redirect_addr_in = '0;
        bus.ex_upd_in           = 1'b0;
        bus.ex_upd_pc_in        = '0;
        bus.ex_upd_taken_in     = 1'b0;
        bus.ex_upd_target_in    = '0;
        bus.if_ready_in         = 1'b1;
    endtask

    logic [31:0] saved;
    int          n;

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #12 rst = 1'b0;
        check_all("reset");
        chk("reset.pc", bus.pc_out, 32'h0);

        // Scenario 1: run to 0x40, async reset, restart from 0.
        n = 0;
        while (m_pc != 32'h40 && n < 40) begin
            cyc("run");
            n++;
        end
        chk("reach_0x40", bus.pc_out, 32'h40);
        mid_reset("rst_mid");
        cyc("boot");  chk("boot.pc", bus.pc_out, 32'h0); chk("boot.v", 32'(bus.pc_valid_out), 32'h1);
        cyc("seq1");  chk("seq1.pc", bus.pc_out, 32'h4);
        cyc("seq2");  chk("seq2.pc", bus.pc_out, 32'h8);

        // Scenario 2: stall bit 0, then IF not ready, both hold PC.
        bus.stall_in = 6'b000001;
        for (int i = 0; i < 3; i++) begin cyc("stall"); chk("stall.pc", bus.pc_out, 32'h8); end
        bus.stall_in = 6'b111110;
        bus.if_ready_in = 1'b0;
        for (int i = 0; i < 2; i++) begin cyc("nrdy"); chk("nrdy.pc", bus.pc_out, 32'h8); end
        bus.if_ready_in = 1'b1;
        cyc("hi_stall_ignored"); chk("hist.pc", bus.pc_out, 32'hC);

        // Scenario 3: redirect with stall active, bubble of 2.
        bus.stall_in = 6'b000001;
        bus.ex_redirect_in = 1'b1; bus.ex_redirect_addr_in = 32'h103;
        cyc("redir"); chk("redir.pc", bus.pc_out, 32'h100); chk("redir.v", 32'(bus.pc_valid_out), 32'h0);
        bus.ex_redirect_in = 1'b0;
        cyc("bub1"); chk("bub1.v", 32'(bus.pc_valid_out), 32'h0);
        cyc("bub2"); chk("bub2.v", 32'(bus.pc_valid_out), 32'h1);
        bus.stall_in = '0;
        cyc("post"); chk("post.pc", bus.pc_out, 32'h104);
        bus.ex_redirect_in = 1'b1; bus.ex_redirect_addr_in = 32'h300;
        cyc("re1");
        bus.ex_redirect_addr_in = 32'h401;
        cyc("re2"); chk("re2.pc", bus.pc_out, 32'h400);
        bus.ex_redirect_in = 1'b0;
        cyc("re3"); chk("re3.v", 32'(bus.pc_valid_out), 32'h0);
        cyc("re4");
        cyc("re5"); chk("re5.pc", bus.pc_out, 32'h404);

        // Scenario 4: rdy_in low drops a redirect; wrap-around at top of space.
        saved = bus.pc_out;
        bus.rdy_in = 1'b0;
        bus.ex_redirect_in = 1'b1; bus.ex_redirect_addr_in = 32'h200;
        cyc("frz1"); chk("frz1.pc", bus.pc_out, saved);
        cyc("frz2"); chk("frz2.pc", bus.pc_out, saved);
        bus.rdy_in = 1'b1; bus.ex_redirect_addr_in = 32'hFFFF_FFFC;
        cyc("wr0");
        bus.ex_redirect_in = 1'b0;
        bus.rdy_in = 1'b0;
        cyc("wr_frz"); chk("wr_frz.v", 32'(bus.pc_valid_out), 32'h0);
        bus.rdy_in = 1'b1;
        cyc("wr1");
        cyc("wr2"); chk("wr2.pc", bus.pc_out, 32'hFFFF_FFFC);
        cyc("wr3"); chk("wr3.pc", bus.pc_out, 32'h0);

        // Scenario 5: BTB write coinciding with a redirect to 0, then fetch into the hit.
        bus.ex_redirect_in = 1'b1; bus.ex_redirect_addr_in = 32'h0;
        bus.ex_upd_in = 1'b1; bus.ex_upd_pc_in = 32'h10;
        bus.ex_upd_taken_in = 1'b1; bus.ex_upd_target_in = 32'h80;
        cyc("bt_w");
        bus.ex_redirect_in = 1'b0; bus.ex_upd_in = 1'b0;
        n = 0;
        while (m_pc != 32'h10 && n < 20) begin cyc("bt_f"); n++; end
        chk("bt_at10", bus.pc_out, 32'h10);
`ifdef PC_BTB_EN
        chk("bt_ptkn", 32'(bus.pred_taken_out), 32'h1);
        chk("bt_ptgt", bus.pred_target_out, 32'h80);
        cyc("bt_jmp"); chk("bt_jmp.pc", bus.pc_out, 32'h80);
`else
        chk("nb_ptkn", 32'(bus.pred_taken_out), 32'h0);
        cyc("nb_seq"); chk("nb_seq.pc", bus.pc_out, 32'h14);
`endif

        // Scenario 6: not-taken update clears the entry.
        bus.ex_redirect_in = 1'b1; bus.ex_redirect_addr_in = 32'h10;
        bus.ex_upd_in = 1'b1; bus.ex_upd_pc_in = 32'h10; bus.ex_upd_taken_in = 1'b0;
        cyc("clr");
        bus.ex_redirect_in = 1'b0; bus.ex_upd_in = 1'b0;
        cyc("clr1");
        cyc("clr2"); chk("clr2.ptkn", 32'(bus.pred_taken_out), 32'h0);
        cyc("clr3"); chk("clr3.pc", bus.pc_out, 32'h14);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.rdy_in              = ($urandom_range(7) != 0);
            bus.if_ready_in         = ($urandom_range(3) != 0);
            bus.stall_in            = 6'($urandom);
            if (bus.stall_in[0]) bus.stall_in[0] = ($urandom_range(2) == 0);
            bus.ex_redirect_in      = ($urandom_range(15) == 0);
            bus.ex_redirect_addr_in = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                               : 32'($urandom_range(255));
            bus.ex_upd_in           = ($urandom_range(3) == 0);
            bus.ex_upd_pc_in        = 32'($urandom_range(127)) << 2;
            bus.ex_upd_taken_in     = $urandom_range(1) != 0;
            bus.ex_upd_target_in    = 32'($urandom_range(255)) << 2;
            if ($urandom_range(199) == 0) mid_reset("rnd_rst");
            cyc("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
